// File: rtl/mdu_seq_if.sv
// Bundle between the EX control path and the iterative multiply/divide sequencer.
// The EX side (master) drives the request; the sequencer (slave) returns status and result.
`timescale 1ns/1ps
interface mdu_seq_if #(parameter int WIDTH = 32);
  logic             i_start_EX;
  logic [2:0]       i_mdu_op_EX;
  logic [WIDTH-1:0] i_rd1_EX;
  logic [WIDTH-1:0] i_rd2_EX;
  logic             i_flush_EX;
  logic             o_busy_EX;
  logic             o_done_EX;
  logic [WIDTH-1:0] o_result_EX;

  modport master (
    output i_start_EX, i_mdu_op_EX, i_rd1_EX, i_rd2_EX, i_flush_EX,
    input  o_busy_EX, o_done_EX, o_result_EX
  );

  modport slave (
    input  i_start_EX, i_mdu_op_EX, i_rd1_EX, i_rd2_EX, i_flush_EX,
    output o_busy_EX, o_done_EX, o_result_EX
  );
endinterface

// File: rtl/mdu_seq.sv
// RV32M iterative multiply/divide sequencer: shift-add multiply, restoring divide, WIDTH iterations.
// Divider datapath is present only when OSIRIS_MDU_DIV_EN is defined; otherwise ops 1xx return 0.
`timescale 1ns/1ps
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  mdu_seq_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               sel_lo_q, sel_lo_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic               is_div_in, sgn1_in, sgn2_in, s1_in, s2_in;
  logic [WIDTH-1:0]   abs1_in, abs2_in;
  logic               special_in;
  logic [WIDTH-1:0]   special_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] step, prod_fix;
  logic [WIDTH-1:0]   fixed_res;

  always_comb begin
    is_div_in = bus.i_mdu_op_EX[2];
    sgn1_in   = bus.i_mdu_op_EX inside {3'b001, 3'b010, 3'b100, 3'b110};
    sgn2_in   = bus.i_mdu_op_EX inside {3'b001, 3'b100, 3'b110};
    s1_in     = sgn1_in & bus.i_rd1_EX[WIDTH-1];
    s2_in     = sgn2_in & bus.i_rd2_EX[WIDTH-1];
    abs1_in   = s1_in ? -bus.i_rd1_EX : bus.i_rd1_EX;
    abs2_in   = s2_in ? -bus.i_rd2_EX : bus.i_rd2_EX;
  end

`ifdef OSIRIS_MDU_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   rem_shift, rem_diff;
  logic             borrow;
  logic             div_unused;
  logic [WIDTH-1:0] div_word;

  assign div_unused = rem_diff[WIDTH];

  // Divide-by-zero and signed overflow never enter the iteration loop.
  always_comb begin
    special_in  = 1'b0;
    special_res = '0;
    if (is_div_in) begin
      if (bus.i_rd2_EX == '0) begin
        special_in  = 1'b1;
        special_res = bus.i_mdu_op_EX[1] ? bus.i_rd1_EX : '1;
      end else if (!bus.i_mdu_op_EX[0] && bus.i_rd1_EX == {1'b1, {(WIDTH-1){1'b0}}}
                   && bus.i_rd2_EX == '1) begin
        special_in  = 1'b1;
        special_res = bus.i_mdu_op_EX[1] ? '0 : bus.i_rd1_EX;
      end
    end
  end
`else
  assign special_in  = is_div_in;
  assign special_res = '0;
`endif

  // One iteration: multiply adds then shifts right; divide shifts left then trial-subtracts.
  always_comb begin
    mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    step    = {mul_sum, prod_q[WIDTH-1:1]};
`ifdef OSIRIS_MDU_DIV_EN
    rem_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, opnd_q};
    borrow    = rem_shift < {1'b0, opnd_q};
    if (div_q) begin
      step = {(borrow ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0]),
              prod_q[WIDTH-2:0], ~borrow};
    end
`endif
  end

  always_comb begin
    prod_fix  = neg_q ? -prod_q : prod_q;
    fixed_res = sel_lo_q ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
`ifdef OSIRIS_MDU_DIV_EN
    div_word = sel_lo_q ? prod_q[WIDTH-1:0] : prod_q[2*WIDTH-1:WIDTH];
    if (div_q) begin
      fixed_res = neg_q ? -div_word : div_word;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    sel_lo_d = sel_lo_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    result_d = result_q;
`ifdef OSIRIS_MDU_DIV_EN
    div_d    = div_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.i_start_EX) begin
          neg_d    = (is_div_in && bus.i_mdu_op_EX[1]) ? s1_in : (s1_in ^ s2_in);
          sel_lo_d = is_div_in ? ~bus.i_mdu_op_EX[1] : (bus.i_mdu_op_EX[1:0] == 2'b00);
          opnd_d   = is_div_in ? abs2_in : abs1_in;
          prod_d   = {{WIDTH{1'b0}}, (is_div_in ? abs1_in : abs2_in)};
          cnt_d    = '0;
`ifdef OSIRIS_MDU_DIV_EN
          div_d    = is_div_in;
`endif
          if (special_in) begin
            state_d  = DONE;
            result_d = special_res;
          end else begin
            state_d = ITER;
          end
        end
      end
      ITER: begin
        prod_d = step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        result_d = fixed_res;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Flush overrides everything, including a same-cycle start.
    if (bus.i_flush_EX) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      sel_lo_q <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      result_q <= '0;
`ifdef OSIRIS_MDU_DIV_EN
      div_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      sel_lo_q <= sel_lo_d;
      opnd_q   <= opnd_d;
      prod_q   <= prod_d;
      result_q <= result_d;
`ifdef OSIRIS_MDU_DIV_EN
      div_q    <= div_d;
`endif
    end
  end

  assign bus.o_busy_EX   = (state_q == ITER) || (state_q == FIX);
  assign bus.o_done_EX   = (state_q == DONE);
  assign bus.o_result_EX = result_q;
endmodule
